uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
Serial-to-parallel receiver that feeds 8-bit characters into the combinational toUpper stage. It samples an asynchronous 8N1 serial line, reassembles each frame LSB-first and presents the byte with a one-cycle valid strobe. Framing errors are flagged, and the byte is not delivered downstream.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 4; counter width is $clog2(CLKS_PER_BIT).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
byte_out  output  8  last good received byte; feeds toUpper .in
byte_valid  output  1  one-cycle pulse: byte_out updated this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled low
parity_err  output  1  one-cycle pulse: parity mismatch (0 unless UART_RX_PARITY_EN)
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - byte_out=8'h00; byte_valid, frame_err, parity_err, busy = 0.
  - State IDLE; both synchronizer flops = 1; bit counter and shift register cleared.
  - Reset mid-frame abandons the frame with no pulse.
- rx passes through a 2-flop synchronizer (rx_s). prev_s holds the previous rx_s.
- Start detect: in IDLE, rx_s==0 && prev_s==1 -> START, tick counter = CLKS_PER_BIT/2 - 1.
  - A line held low (break) never retriggers a start until it returns high.
- The tick counter decrements each clk. A sample is taken when counter==0; counter then reloads CLKS_PER_BIT-1.
- START, on sample:
  - rx_s==1 -> glitch: IDLE, no pulse.
  - rx_s==0 -> DATA, bit index=0.
- DATA, on sample: shift rx_s into bit[index], LSB first.
  - Index 7 -> PARITY if the macro is defined, else STOP.
- STOP, on sample:
  - rx_s==1 -> byte_out<=shift, byte_valid=1 for exactly one cycle, IDLE.
  - rx_s==0 -> frame_err=1 for one cycle; byte_out holds its previous value; IDLE.
- Pulses are registered and appear in the cycle after the sampling edge.
  - byte_valid and frame_err are never high together.
- Latency: byte_valid rises about 9.5*CLKS_PER_BIT + 3 cycles after the rx falling edge.
- Back-to-back frames: the STOP->IDLE transition happens at the stop-bit midpoint, so a start edge half a bit later is caught with zero idle time.
- busy=1 from the START entry edge through the cycle the stop sample is taken.
- Bytes 0x00-0xFF are all legal; no filtering. toUpper performs all character handling.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - Extra PARITY state after DATA expects an even-parity bit.
  - Mismatch -> parity_err one-cycle pulse at the STOP sample (in place of byte_valid); byte_out unchanged.
  - A stop bit sampled low reports frame_err only.
  - Frame length is 11 bits.
- Not defined:
  - No PARITY state; parity_err is tied 0.
  - Frame length is 10 bits.

Test Plan:
- Reset, then send 0x61 ('a') at 16 clk/bit -> single byte_valid pulse with byte_out=0x61; downstream toUpper shows 0x41; busy low afterwards.
- 3-cycle low glitch on idle rx -> START aborts; no byte_valid or frame_err; busy high for at most 8 cycles.
- Send 0x48, then 0x41 with stop bit forced 0 -> frame_err pulse on the second frame; byte_out stays 0x48; no byte_valid for 0x41.
- Back-to-back 0x7A, 0x7B, 0x7F with no idle bits -> three byte_valid pulses in order, each with the correct byte_out; no errors.
- Assert rst_n low during bit 4 of 0xEB, then send 0x30 -> no pulse for 0xEB; all outputs 0 during reset; 0x30 received correctly.
- With UART_RX_PARITY_EN: send 0x61 with parity bit 0 (odd count of ones) -> parity_err pulse, no byte_valid. Resend with parity bit 1 -> byte_valid with 0x61.

Source files
------------

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver that delivers each character to toUpper.
// It synchronises the asynchronous rx line, finds the start edge and samples
// every bit at its midpoint. Data arrives LSB first. A good byte is presented
// on byte_out together with a one-cycle byte_valid strobe. A bad stop bit
// gives a one-cycle frame_err pulse, and byte_out keeps its previous value.
// Build option: define UART_RX_PARITY_EN to add an even-parity bit after the
// data. The frame is then 11 bits long and parity_err is live.
`timescale 1ns/1ps

module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    // The first sample lands half a bit after the start edge, at the middle of the start bit.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    // Every later sample lands one full bit after the one before.
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } state_e;

    // Synchroniser and edge-detect history
    logic sync1_q;
    logic rx_s_q;
    logic prev_s_q;

    // Frame engine state
    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       idx_q,    idx_d;
    logic [7:0]       shift_q,  shift_d;
    logic [7:0]       byte_q,   byte_d;
    logic             valid_q,  valid_d;
    logic             ferr_q,   ferr_d;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             perr_q,    perr_d;
`endif

    logic sample;
    logic start_edge;

    // The bit midpoint is reached when the tick counter runs out.
    assign sample     = (cnt_q == '0);
    // Start only on a real high-to-low edge. A line held low (break) cannot retrigger.
    assign start_edge = !rx_s_q && prev_s_q;

    // Two-flop synchroniser for the asynchronous line, plus one flop of history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these reset to the idle-high line level, so releasing reset cannot fake a start edge.
            sync1_q  <= 1'b1;
            rx_s_q   <= 1'b1;
            prev_s_q <= 1'b1;
        end else begin
            // NOTE: all sequential state uses non-blocking assignments. Every flop then
            // updates from the same pre-edge values, whatever the statement order.
            sync1_q  <= rx;
            rx_s_q   <= sync1_q;
            prev_s_q <= rx_s_q;
        end
    end

    // Next-state logic: tick counting, bit capture and the end-of-frame verdict.
    always_comb begin
        // NOTE: every signal gets a default before the case statement. Paths that
        // do not assign a signal then hold or clear it, and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif

        if (state_q != ST_IDLE) begin
            cnt_d = sample ? FULL_LOAD : cnt_q - CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_START;
                    cnt_d   = HALF_LOAD;
                end
            end

            ST_START: begin
                if (sample) begin
                    if (rx_s_q) begin
                        // The line is high again at the start-bit midpoint, so this was a glitch. Drop it silently.
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = 3'd0;
                    end
                end
            end

            ST_DATA: begin
                if (sample) begin
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (sample) begin
                    // Even parity: the XOR of the data and parity bits must be 0.
                    par_bad_d = (^shift_q) ^ rx_s_q;
                    state_d   = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                if (sample) begin
                    // Return to IDLE at the stop-bit midpoint. A start edge half a bit later is then caught.
                    state_d = ST_IDLE;
                    if (!rx_s_q) begin
                        // A low stop bit is a framing error. It takes priority over any parity result.
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One register stage for the whole frame engine. The status pulses leave from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit. It covers the reset
// state, a single byte with its latency, a start glitch, a framing error,
// back-to-back frames and reset in mid-frame. The parity cases run only
// when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps

module tb_uart_rx_byte;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    int cyc          = 0;
    int valid_cnt    = 0;
    int ferr_cnt     = 0;
    int perr_cnt     = 0;
    int busy_cycles  = 0;
    int last_valid_cyc = 0;
    int frame_start_cyc = 0;
    logic [7:0] got_q[$];

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared = n_compared + 1;
        assert (observed === expected) else begin
            n_mismatched = n_mismatched + 1;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
            $error("check %s mismatched", tag);
        end
    endtask

    // Pulse monitor, sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (busy) busy_cycles = busy_cycles + 1;
        if (byte_valid || frame_err) check("valid_ferr_exclusive", 32'(byte_valid & frame_err), 32'd0);
        if (byte_valid) begin
            valid_cnt = valid_cnt + 1;
            got_q.push_back(byte_out);
            last_valid_cyc = cyc;
        end
        if (frame_err)  ferr_cnt = ferr_cnt + 1;
        if (parity_err) perr_cnt = perr_cnt + 1;
    end

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_cycles(CPB);
    endtask

    // Whole frame: start, 8 data bits LSB first, optional parity, stop.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit);
        frame_start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_bit);
`else
        if (par_bit) begin end
`endif
        send_bit(stop_bit);
    endtask

    task automatic pop_byte(input string tag, input logic [7:0] expected);
        logic [7:0] b;
        b = 8'hxx;
        if (got_q.size() != 0) b = got_q.pop_front();
        check(tag, 32'(b), 32'(expected));
    endtask

    int v0, f0, p0;

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        wait_cycles(3);
        check("reset_byte_out", 32'(byte_out), 32'h00);
        check("reset_flags", 32'({byte_valid, frame_err, parity_err, busy}), 32'd0);
        rst_n = 1'b1;
        wait_cycles(4);
        check("idle_busy", 32'(busy), 32'd0);

        // Single byte 'a', with its latency from the rx fall.
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h61, 1'b1, 1'b1);
        wait_cycles(2);
        check("a_valid_count", 32'(valid_cnt - v0), 32'd1);
        pop_byte("a_byte", 8'h61);
        check("a_to_upper", 32'(to_upper(byte_out)), 32'h41);
        check("a_latency", 32'(last_valid_cyc - frame_start_cyc), 32'd155);
        check("a_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("a_busy_after", 32'(busy), 32'd0);

        // 3-cycle low glitch on the idle line.
        v0 = valid_cnt; f0 = ferr_cnt; busy_cycles = 0;
        rx = 1'b0;
        wait_cycles(3);
        rx = 1'b1;
        wait_cycles(2 * CPB);
        check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("glitch_busy_bounded", 32'(busy_cycles >= 1 && busy_cycles <= 8), 32'd1);

        // Good 0x48, then 0x41 with its stop bit forced low.
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h48, 1'b1, 1'b0);
        send_frame(8'h41, 1'b0, 1'b0);
        rx = 1'b1;
        wait_cycles(2 * CPB);
        check("ferr_valid_count", 32'(valid_cnt - v0), 32'd1);
        pop_byte("ferr_first_byte", 8'h48);
        check("ferr_count", 32'(ferr_cnt - f0), 32'd1);
        check("ferr_byte_held", 32'(byte_out), 32'h48);

        // Back-to-back frames with no idle time between them.
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h7A, 1'b1, 1'b1);
        send_frame(8'h7B, 1'b1, 1'b0);
        send_frame(8'h7F, 1'b1, 1'b1);
        wait_cycles(4);
        check("b2b_valid_count", 32'(valid_cnt - v0), 32'd3);
        pop_byte("b2b_byte0", 8'h7A);
        pop_byte("b2b_byte1", 8'h7B);
        pop_byte("b2b_byte2", 8'h7F);
        check("b2b_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Reset in the middle of bit 4 of 0xEB.
        v0 = valid_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b0;
        wait_cycles(CPB / 2);
        rst_n = 1'b0;
        #1;
        check("midrst_byte_out", 32'(byte_out), 32'h00);
        check("midrst_flags", 32'({byte_valid, frame_err, parity_err, busy}), 32'd0);
        rx = 1'b1;
        wait_cycles(CPB);
        rst_n = 1'b1;
        wait_cycles(CPB);
        check("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
        send_frame(8'h30, 1'b1, 1'b0);
        wait_cycles(2);
        check("post_rst_valid_count", 32'(valid_cnt - v0), 32'd1);
        pop_byte("post_rst_byte", 8'h30);

`ifdef UART_RX_PARITY_EN
        // Wrong parity for 0x61 (three ones), then the correct parity.
        v0 = valid_cnt; p0 = perr_cnt;
        send_frame(8'h61, 1'b1, 1'b0);
        wait_cycles(2);
        check("par_bad_perr", 32'(perr_cnt - p0), 32'd1);
        check("par_bad_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("par_bad_byte_held", 32'(byte_out), 32'h30);
        send_frame(8'h61, 1'b1, 1'b1);
        wait_cycles(2);
        check("par_good_valid", 32'(valid_cnt - v0), 32'd1);
        pop_byte("par_good_byte", 8'h61);
        check("par_good_perr", 32'(perr_cnt - p0), 32'd1);
`else
        p0 = 0;
        check("no_parity_err_ever", 32'(perr_cnt - p0), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
